// File: rtl/timer_ctrl.sv
// timer_ctrl: run/pause/clear sequencer for the 1 Hz timer datapath and its 7-seg display
//   i_clk          system clock
//   i_rstn         asynchronous reset, active-high despite the name
//   i_tick         1-cycle 1 Hz enable
//   i_btn_start_n  raw start/pause button, low = pressed
//   i_btn_clr_n    raw clear button, low = pressed
//   i_cnt_done     datapath is at terminal count
//   o_cnt_en       count enable to the datapath
//   o_cnt_clr      1-cycle clear to the datapath
//   o_seg_blank    blank all digits
//   o_alarm        alarm indicator
//   o_state        00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
module timer_ctrl #(
   parameter int DB_CYCLES   = 1_000_000,
   parameter int DB_W        = 20,
   parameter int ALARM_TICKS = 5
) (
   input  logic       i_clk,
   input  logic       i_rstn,
   input  logic       i_tick,
   input  logic       i_btn_start_n,
   input  logic       i_btn_clr_n,
   input  logic       i_cnt_done,
   output logic       o_cnt_en,
   output logic       o_cnt_clr,
   output logic       o_seg_blank,
   output logic       o_alarm,
   output logic [1:0] o_state
);
   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_RUN   = 2'b01;
   localparam logic [1:0] S_PAUSE = 2'b10;
   localparam logic [1:0] S_DONE  = 2'b11;
   localparam int AW = $clog2(ALARM_TICKS + 1);
   // bit 0 = start button, bit 1 = clear button
   logic [1:0]      r_s1, r_s2, r_acc, r_press;
   logic [DB_W-1:0] r_db [2];
   logic [1:0]      r_state, w_next;
   logic            r_clr, r_phase;
   logic [AW-1:0]   r_acnt;
   logic            w_start_p, w_clr_p;
   assign w_start_p = r_press[0];
   assign w_clr_p   = r_press[1];
   // 2-FF synchronizer, then a level must stay different for DB_CYCLES before it is accepted;
   // the press pulse is registered together with the accepted 1->0 update
   always_ff @(posedge i_clk or posedge i_rstn)
      if (i_rstn) begin
         r_s1    <= '1;
         r_s2    <= '1;
         r_acc   <= '1;
         r_press <= '0;
         r_db[0] <= '0;
         r_db[1] <= '0;
      end else begin
         r_s1 <= {i_btn_clr_n, i_btn_start_n};
         r_s2 <= r_s1;
         for (int i = 0; i < 2; i++) begin
            if (r_s2[i] != r_acc[i] && r_db[i] == DB_W'(DB_CYCLES - 1)) begin
               r_acc[i]   <= r_s2[i];
               r_db[i]    <= '0;
               r_press[i] <= ~r_s2[i];
            end else begin
               r_db[i]    <= (r_s2[i] != r_acc[i]) ? r_db[i] + 1'b1 : '0;
               r_press[i] <= 1'b0;
            end
         end
      end
   // clear wins over everything; terminal tick in RUN wins over start
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = (!w_clr_p && w_start_p) ? S_RUN : S_IDLE;
         S_RUN:   w_next = w_clr_p ? S_IDLE : (i_tick && i_cnt_done) ? S_DONE : w_start_p ? S_PAUSE : S_RUN;
         S_PAUSE: w_next = w_clr_p ? S_IDLE : w_start_p ? S_RUN : S_PAUSE;
         default: w_next = w_clr_p ? S_IDLE : S_DONE;
      endcase
   end
   always_ff @(posedge i_clk or posedge i_rstn)
      if (i_rstn) begin
         r_state <= S_IDLE;
         r_clr   <= 1'b0;
         r_phase <= 1'b0;
         r_acnt  <= '0;
      end else begin
         r_state <= w_next;
         r_clr   <= w_clr_p;
         // blink only while staying in PAUSE/DONE, so entry always starts lit
         r_phase <= (w_next == r_state && r_state[1]) ? r_phase ^ i_tick : 1'b0;
         if (r_state == S_RUN && w_next == S_DONE)
            r_acnt <= AW'(ALARM_TICKS);
         else if (r_state == S_DONE && i_tick && r_acnt != '0)
            r_acnt <= r_acnt - 1'b1;
      end
   assign o_cnt_en    = i_tick && r_state == S_RUN && !i_cnt_done;
   assign o_cnt_clr   = r_clr;
   assign o_seg_blank = r_phase;
   assign o_alarm     = r_state == S_DONE && r_acnt != '0;
   assign o_state     = r_state;
endmodule
